des_round_ctrl: RTL

//  Sequencer and key schedule for the iterative DES core. Accepts one block/key
//  job, drives load_init/round_en into the L/R registers, and supplies K1..K16
//  (K16..K1 when decrypting) one per round. Also handshakes the result out.

---
 rtl/des_pkg.sv | 62 ++++++
 rtl/des_round_ctrl_if.sv | 28 ++
 rtl/des_key_cd_reg.sv | 51 +++++
 rtl/des_round_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared constants, tables and helper functions for the DES key-schedule sequencer.
// PC-1/PC-2 use FIPS bit numbering: bit 1 is the MSB of the source word.
package des_pkg;

    localparam int KEY_W  = 64;
    localparam int CD_W   = 56;
    localparam int HALF_W = 28;
    localparam int SK_W   = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The decrypt table starts with 0 so that round 0 reuses C0/D0, which equals C16/D16.
    localparam logic [1:0] SHIFT_ENC [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                              2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    localparam logic [1:0] SHIFT_DEC [16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                              2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    localparam int PC1_TAB [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TAB [SK_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
        logic [CD_W-1:0] res;
        res = '0;
        for (int i = 0; i < CD_W; i++) begin
            res[6'(CD_W - 1 - i)] = key[6'(KEY_W - PC1_TAB[i])];
        end
        return res;
    endfunction

    function automatic logic [SK_W-1:0] pc2(input logic [CD_W-1:0] cd);
        logic [SK_W-1:0] res;
        res = '0;
        for (int i = 0; i < SK_W; i++) begin
            res[6'(SK_W - 1 - i)] = cd[6'(CD_W - PC2_TAB[i])];
        end
        return res;
    endfunction

    // Every key byte must carry odd parity.
    function automatic logic key_parity_ok(input logic [KEY_W-1:0] key);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            ok = ok & (^key[6'(8 * b) +: 8]);
        end
        return ok;
    endfunction

endpackage

// File: rtl/des_round_ctrl_if.sv
// Job/result handshake and round-control bundle between the sequencer and its user.
interface des_round_ctrl_if;
    import des_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [KEY_W-1:0]  key_in;
    logic              decrypt;
    logic              load_init;
    logic              round_en;
    logic [3:0]        round_idx;
    logic [SK_W-1:0]   subkey;
    logic              out_valid;
    logic              out_ready;
    logic              key_err;
    logic              busy;

    modport master (
        output in_valid, key_in, decrypt, out_ready,
        input  in_ready, load_init, round_en, round_idx, subkey, out_valid, key_err, busy
    );

    modport slave (
        input  in_valid, key_in, decrypt, out_ready,
        output in_ready, load_init, round_en, round_idx, subkey, out_valid, key_err, busy
    );

endinterface

// File: rtl/des_key_cd_reg.sv
// C/D key register: loads PC-1 output, rotates both 28-bit halves by 0/1/2 per round.
// cd_rot is the rotated view of the current contents, used both for the subkey and the update.
module des_key_cd_reg
    import des_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [CD_W-1:0] load_val,
    input  logic            shift_en,
    input  logic            dir_right,
    input  logic [1:0]      amt,
    output logic [CD_W-1:0] cd_rot
);

    logic [CD_W-1:0] cd_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_half
            logic [HALF_W-1:0] cur;
            logic [HALF_W-1:0] rot;

            assign cur = cd_reg[gi*HALF_W +: HALF_W];

            always_comb begin
                rot = cur;
                case (amt)
                    2'd1: rot = dir_right ? {cur[0], cur[HALF_W-1:1]}
                                          : {cur[HALF_W-2:0], cur[HALF_W-1]};
                    2'd2: rot = dir_right ? {cur[1:0], cur[HALF_W-1:2]}
                                          : {cur[HALF_W-3:0], cur[HALF_W-1:HALF_W-2]};
                    default: rot = cur;
                endcase
            end

            assign cd_rot[gi*HALF_W +: HALF_W] = rot;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cd_reg <= '0;
        end else if (load) begin
            cd_reg <= load_val;
        end else if (shift_en) begin
            cd_reg <= cd_rot;
        end
    end

endmodule

// File: rtl/des_round_ctrl.sv
// Round sequencer for the iterative DES core: accepts a key job, runs 16 rounds
// with one subkey per round, then holds the result until the consumer takes it.
module des_round_ctrl
    import des_pkg::*;
#(
    parameter int ROUNDS       = 16,
    parameter bit PARITY_CHECK = 1'b0
) (
    input logic            clk,
    input logic            rst,
    des_round_ctrl_if.slave bus
);

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    state_t          state_reg, state_next;
    logic [3:0]      cnt_reg, cnt_next;
    logic            mode_reg, mode_next;

    logic            key_ok;
    logic            in_ready_c, load_init_c, round_en_c, out_valid_c, key_err_c;
    logic [1:0]      shift_amt;
    logic [CD_W-1:0] cd_rot;

    assign key_ok    = !PARITY_CHECK || key_parity_ok(bus.key_in);
    assign shift_amt = mode_reg ? SHIFT_DEC[cnt_reg] : SHIFT_ENC[cnt_reg];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            mode_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        mode_next   = mode_reg;
        in_ready_c  = 1'b0;
        load_init_c = 1'b0;
        round_en_c  = 1'b0;
        out_valid_c = 1'b0;
        key_err_c   = 1'b0;

        case (state_reg)
            IDLE: begin
                in_ready_c = 1'b1;
            end
            ROUND: begin
                round_en_c = 1'b1;
                if (cnt_reg == LAST_ROUND) begin
                    cnt_next   = '0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                in_ready_c  = bus.out_ready;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A job offered while ready either starts immediately (also from DONE) or is rejected.
        if (in_ready_c && bus.in_valid) begin
            if (key_ok) begin
                load_init_c = 1'b1;
                mode_next   = bus.decrypt;
                cnt_next    = '0;
                state_next  = ROUND;
            end else begin
                key_err_c = 1'b1;
            end
        end
    end

    des_key_cd_reg u_cd (
        .clk       (clk),
        .rst       (rst),
        .load      (load_init_c),
        .load_val  (pc1(bus.key_in)),
        .shift_en  (round_en_c),
        .dir_right (mode_reg),
        .amt       (shift_amt),
        .cd_rot    (cd_rot)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.load_init = load_init_c;
    assign bus.round_en  = round_en_c;
    assign bus.round_idx = round_en_c ? cnt_reg : 4'd0;
    assign bus.subkey    = round_en_c ? pc2(cd_rot) : '0;
    assign bus.out_valid = out_valid_c;
    assign bus.key_err   = key_err_c;
    assign bus.busy      = (state_reg != IDLE);

endmodule
